// File: rtl/sys_array_arbiter_if.sv
// rtl/sys_array_arbiter_if.sv - requester/fetcher bus bundle for sys_array_arbiter
interface sys_array_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4
) ();
  localparam int MW = DATA_WIDTH * ARRAY_W * ARRAY_L;
  localparam int RW = 2 * DATA_WIDTH * ARRAY_W * ARRAY_W;

  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [MW-1:0] req_a0;
  logic [MW-1:0] req_a1;
  logic [MW-1:0] req_b0;
  logic [MW-1:0] req_b1;
  logic [1:0]    resp_valid;
  logic [RW-1:0] resp_data;
  logic          busy;
  logic          f_load_params;
  logic          f_start_comp;
  logic [MW-1:0] f_data_a;
  logic [MW-1:0] f_data_b;
  logic [RW-1:0] f_out_data;

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, f_out_data,
    output req_ready, resp_valid, resp_data, busy,
           f_load_params, f_start_comp, f_data_a, f_data_b
  );

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, f_out_data,
    input  req_ready, resp_valid, resp_data, busy,
           f_load_params, f_start_comp, f_data_a, f_data_b
  );
endinterface

// File: rtl/sys_array_arbiter.sv
// rtl/sys_array_arbiter.sv - two-requester arbiter sharing one systolic-array fetcher
module sys_array_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_W     = 4,
  parameter int ARRAY_L     = 4,
  parameter int COMP_CYCLES = ARRAY_L + 2 * ARRAY_W + 4
) (
  input logic             clock,
  input logic             reset_n,
  sys_array_arbiter_if.slave bus
);
  localparam int MW = DATA_WIDTH * ARRAY_W * ARRAY_L;
  localparam int RW = 2 * DATA_WIDTH * ARRAY_W * ARRAY_W;
  localparam int CW = $clog2(COMP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          prio;
  logic          owner;
  logic          param_ok;
  logic [CW-1:0] counter;
  logic [MW-1:0] a_reg;
  logic [MW-1:0] b_reg;
  logic [MW-1:0] b_cache;
  logic [RW-1:0] resp_reg;

  logic          win;
  logic          accept;
  logic [MW-1:0] sel_a;
  logic [MW-1:0] sel_b;
  logic [1:0]    ready_c;
  logic [1:0]    resp_valid_c;
  logic          load_c;
  logic          start_c;

  // Priority pointer only matters when both requesters contend.
  always_comb begin
    win = prio;
    if (bus.req_valid == 2'b01) win = 1'b0;
    else if (bus.req_valid == 2'b10) win = 1'b1;
  end

  assign sel_a  = win ? bus.req_a1 : bus.req_a0;
  assign sel_b  = win ? bus.req_b1 : bus.req_b0;
  assign accept = (state == IDLE) && bus.req_valid[win];

  always_comb begin
    state_next   = state;
    ready_c      = 2'b00;
    resp_valid_c = 2'b00;
    load_c       = 1'b0;
    start_c      = 1'b0;
    case (state)
      IDLE: begin
        ready_c[win] = bus.req_valid[win];
        if (accept)
          state_next = (param_ok && (sel_b == b_cache)) ? START : LOAD;
      end
      LOAD: begin
        load_c     = 1'b1;
        state_next = START;
      end
      START: begin
        start_c    = 1'b1;
        state_next = WAIT;
      end
      // Fetcher ready is sticky, so completion is timed purely by the counter.
      WAIT: begin
        if (counter == '0) state_next = DONE;
      end
      DONE: begin
        resp_valid_c[owner] = 1'b1;
        state_next          = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      param_ok <= 1'b0;
      counter  <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      b_cache  <= '0;
      resp_reg <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            owner <= win;
            a_reg <= sel_a;
            b_reg <= sel_b;
          end
        end
        LOAD: begin
          b_cache  <= b_reg;
          param_ok <= 1'b1;
        end
        START: counter <= CW'(COMP_CYCLES - 1);
        WAIT: begin
          if (counter == '0) resp_reg <= bus.f_out_data;
          else counter <= counter - 1'b1;
        end
        DONE: prio <= ~owner;
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.resp_valid    = resp_valid_c;
  assign bus.resp_data     = resp_reg;
  assign bus.busy          = (state != IDLE);
  assign bus.f_load_params = load_c;
  assign bus.f_start_comp  = start_c;
  assign bus.f_data_a      = a_reg;
  assign bus.f_data_b      = b_reg;
endmodule

// File: tb/tb_sys_array_arbiter.sv
// tb/tb_sys_array_arbiter.sv - scoreboard bench for sys_array_arbiter
module tb_sys_array_arbiter;
  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int L    = 4;
  localparam int COMP = L + 2 * W + 4;
  localparam int MW   = DW * W * L;
  localparam int RW   = 2 * DW * W * W;

  typedef struct {
    logic          owner;
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;

  logic clock;
  logic reset_n;

  sys_array_arbiter_if #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L)) bus ();

  sys_array_arbiter #(
    .DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L), .COMP_CYCLES(COMP)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [RW-1:0] prod(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [RW-1:0]   r;
    logic [2*DW-1:0] acc;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int k = 0; k < W; k++) begin
        acc = '0;
        for (int j = 0; j < L; j++)
          acc += a[(i*L+j)*DW +: DW] * b[(j*W+k)*DW +: DW];
        r[(i*W+k)*2*DW +: 2*DW] = acc;
      end
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] r;
    for (int i = 0; i < MW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Fetcher model: result is only valid COMP cycles after the start strobe, complement before.
  int            fcnt = 0;
  logic [RW-1:0] fprod;
  always @(posedge clock) begin
    if (bus.f_start_comp) begin
      fprod          <= prod(bus.f_data_a, bus.f_data_b);
      bus.f_out_data <= ~prod(bus.f_data_a, bus.f_data_b);
      fcnt           <= 1;
    end else if (fcnt != 0) begin
      fcnt <= fcnt + 1;
      if (fcnt == COMP - 1) begin
        bus.f_out_data <= fprod;
        fcnt           <= 0;
      end
    end
  end

  int            passed = 0;
  int            total  = 0;
  int            cyc    = 0;
  bit            chk_en = 0;
  exp_t          sb[$];
  int            acc_log[$];
  int            acc_count = 0;
  bit            job_on = 0;
  logic          j_owner;
  int            j_acc, j_load, j_start, j_done;
  logic [MW-1:0] j_a, j_b;
  logic [RW-1:0] j_data;
  logic          m_prio = 0;
  bit            m_ok = 0;
  logic [MW-1:0] m_cache = '0;
  logic [RW-1:0] m_resp = '0;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_cycle();
    logic       exp_busy;
    logic       w;
    logic [1:0] exp_ready;
    logic [1:0] exp_rv;
    logic [MW-1:0] a, b;
    bit         reuse;
    exp_t       e;
    exp_busy = job_on && cyc > j_acc && cyc <= j_done;
    chk("busy", bus.busy, exp_busy);
    chk("f_load_params", bus.f_load_params, job_on && cyc == j_load);
    chk("f_start_comp", bus.f_start_comp, job_on && cyc == j_start);
    if (job_on && cyc == j_done) m_resp = j_data;
    chk("resp_data_hold", bus.resp_data, m_resp);
    exp_rv = (job_on && cyc == j_done) ? (2'b01 << j_owner) : 2'b00;
    chk("resp_valid", bus.resp_valid, exp_rv);
    if (bus.resp_valid != 2'b00) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_owner", bus.resp_valid, 2'b01 << e.owner);
        chk("sb_data", bus.resp_data, e.data);
        chk("sb_cycle", cyc, e.cyc);
      end
    end
    if (exp_busy) begin
      chk("f_data_a_stable", bus.f_data_a, j_a);
      chk("f_data_b_stable", bus.f_data_b, j_b);
    end
    w = (bus.req_valid == 2'b11) ? m_prio : bus.req_valid[1];
    exp_ready = 2'b00;
    if (!exp_busy && bus.req_valid != 2'b00) exp_ready[w] = 1'b1;
    chk("req_ready", bus.req_ready, exp_ready);
    if (job_on && cyc == j_done) begin
      m_prio = ~j_owner;
      job_on = 0;
    end
    if (reset_n && exp_ready != 2'b00) begin
      a = w ? bus.req_a1 : bus.req_a0;
      b = w ? bus.req_b1 : bus.req_b0;
      reuse = m_ok && (b == m_cache);
      if (!reuse) begin
        m_cache = b;
        m_ok    = 1;
      end
      job_on  = 1;
      j_owner = w;
      j_acc   = cyc;
      j_load  = reuse ? -1 : cyc + 1;
      j_start = cyc + (reuse ? 1 : 2);
      j_done  = j_start + COMP + 1;
      j_a     = a;
      j_b     = b;
      j_data  = prod(a, b);
      sb.push_back('{owner: w, data: j_data, cyc: j_done});
      acc_log.push_back(int'(w));
      acc_count++;
    end
    if (!reset_n) begin
      job_on = 0;
      m_prio = 0;
      m_ok   = 0;
      m_resp = '0;
      sb.delete();
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (chk_en) check_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && job_on; i++) tick();
    chk("done_timeout", job_on, 0);
    tick();
  endtask

  task automatic run_job(input int k, input logic [MW-1:0] a, input logic [MW-1:0] b);
    int start_acc;
    start_acc = acc_count;
    if (k == 0) begin bus.req_a0 = a; bus.req_b0 = b; end
    else begin bus.req_a1 = a; bus.req_b1 = b; end
    bus.req_valid    = 2'b00;
    bus.req_valid[k] = 1'b1;
    for (int i = 0; i < 40 && acc_count == start_acc; i++) tick();
    chk("accept_timeout", acc_count != start_acc, 1);
    bus.req_valid = 2'b00;
    wait_idle();
  endtask

  task automatic apply_reset();
    reset_n = 0;
    tick();
    tick();
    reset_n = 1;
  endtask

  logic [MW-1:0] ident, cnt_a, rb;
  int            base;

  initial begin
    ident = '0;
    for (int j = 0; j < L; j++) ident[(j*W+j)*DW +: DW] = 8'd1;
    for (int n = 0; n < W * L; n++) cnt_a[n*DW +: DW] = DW'(n + 1);
    reset_n       = 0;
    bus.req_valid = 2'b00;
    bus.req_a0    = '0;
    bus.req_a1    = '0;
    bus.req_b0    = '0;
    bus.req_b1    = '0;
    repeat (3) begin @(posedge clock); #1; end
    chk("rst_busy", bus.busy, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_f_data_a", bus.f_data_a, 0);
    chk("rst_f_data_b", bus.f_data_b, 0);
    chk("rst_load", bus.f_load_params, 0);
    chk("rst_start", bus.f_start_comp, 0);
    reset_n = 1;
    chk_en  = 1;

    // Single job, identity B: result equals A widened.
    run_job(0, cnt_a, ident);
    chk("ident_result", bus.resp_data, prod(cnt_a, ident));
    // Same B again: reuse path, no load strobe.
    run_job(0, rnd_mat(), ident);
    // Requester 1 with a new B forces a reload.
    rb = rnd_mat();
    run_job(1, rnd_mat(), rb);
    run_job(0, rnd_mat(), rb);

    // Contention from reset: expect owners 0, 1, 0 back to back.
    apply_reset();
    bus.req_a0 = rnd_mat(); bus.req_b0 = rnd_mat();
    bus.req_a1 = rnd_mat(); bus.req_b1 = rnd_mat();
    base = acc_count;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 100 && acc_count < base + 3; i++) tick();
    bus.req_valid = 2'b00;
    chk("cont_accepts", acc_count - base, 3);
    if (acc_count >= base + 3) begin
      chk("cont_owner_a", acc_log[base], 0);
      chk("cont_owner_b", acc_log[base+1], 1);
      chk("cont_owner_c", acc_log[base+2], 0);
      chk("cont_back_to_back", (acc_log.size() >= base + 3) ? 1 : 0, 1);
    end
    wait_idle();

    // Abort in WAIT with counter at 5, then confirm identity B is reloaded.
    run_job(0, cnt_a, ident);
    base = acc_count;
    bus.req_a0 = rnd_mat(); bus.req_b0 = ident;
    bus.req_valid = 2'b01;
    for (int i = 0; i < 40 && acc_count == base; i++) tick();
    bus.req_valid = 2'b00;
    chk("abort_accept", acc_count - base, 1);
    while (cyc < j_start + 11) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("abort_busy", bus.busy, 0);
    repeat (25) tick();
    run_job(0, cnt_a, ident);

    for (int n = 0; n < 3; n++) run_job(n % 2, rnd_mat(), (n == 2) ? rb : rnd_mat());
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sys_array_arbiter.md
SYS_ARRAY_ARBITER -- requirements
Module: sys_array_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
  DATA_WIDTH, 8, operand element width.
  ARRAY_W, 4, array rows/cols of result (i).
  ARRAY_L, 4, array inner dimension (j).
  COMP_CYCLES, 16, cycles from f_start_comp to valid f_out_data (ARRAY_L+2*ARRAY_W+4).
REQ-002 Ports (name, direction, width, meaning); MW = DATA_WIDTH*ARRAY_W*ARRAY_L, RW = 2*DATA_WIDTH*ARRAY_W*ARRAY_W:
  clock  in  1  clock, all logic on rising edge.
  reset_n  in  1  reset, synchronous, active-low.
  req_valid  in  2  per-requester job request.
  req_ready  out  2  per-requester accept; combinational.
  req_a0, req_a1  in  MW  requester 0/1 matrix A.
  req_b0, req_b1  in  MW  requester 0/1 matrix B (parameters).
  resp_valid  out  2  per-requester one-cycle result strobe.
  resp_data  out  RW  result matrix, shared by both requesters.
  busy  out  1  high in any state other than IDLE.
  f_load_params  out  1  fetcher parameter-load strobe.
  f_start_comp  out  1  fetcher start strobe.
  f_data_a  out  MW  fetcher A operand.
  f_data_b  out  MW  fetcher B operand.
  f_out_data  in  RW  fetcher result.

Function
REQ-003 FSM states: IDLE, LOAD, START, WAIT, DONE; one job in flight at a time.
REQ-004 IDLE: req_ready[k] SHALL be 1 only for the arbitration winner k; both bits 0 in every other state.
REQ-005 Arbitration: single valid wins; both valid -> requester equal to priority pointer prio wins; prio resets to 0.
REQ-006 Accept = req_valid[k] & req_ready[k]; on accept, register owner=k, A_reg=req_ak, B_reg=req_bk.
REQ-007 Accept transition: next state LOAD unless param_ok=1 and req_bk==B_cache, then next state START (parameter reuse).
REQ-008 LOAD: f_load_params=1 for exactly one cycle; B_cache<=B_reg, param_ok<=1; next START.
REQ-009 START: f_start_comp=1 for exactly one cycle; wait counter loaded with COMP_CYCLES-1; next WAIT.
REQ-010 f_data_a SHALL equal A_reg and f_data_b SHALL equal B_reg from the cycle after accept until DONE, unchanged.
REQ-011 WAIT: counter decrements each cycle; at counter==0, resp_data<=f_out_data; next DONE. Fetcher ready is sticky and SHALL NOT be used.
REQ-012 DONE: resp_valid[owner]=1 for exactly one cycle; prio<=~owner; next IDLE.
REQ-013 resp_data SHALL hold its value until next DONE capture; requesters sample it on resp_valid.
REQ-014 Latency: accept at cycle t -> resp_valid at t+COMP_CYCLES+3 (LOAD path) or t+COMP_CYCLES+2 (reuse path).
REQ-015 req_valid deasserting while not accepted SHALL be ignored; no request is queued inside the block.
REQ-016 f_load_params and f_start_comp SHALL never be high in the same cycle.
REQ-017 Back-to-back: a request valid in the IDLE cycle after DONE SHALL be accepted that cycle.

Reset
REQ-018 reset_n=0 at a clock edge: state=IDLE, prio=0, param_ok=0, counter=0, resp_valid=0, busy=0, f_load_params=0, f_start_comp=0, resp_data=0, A_reg=B_reg=B_cache=0.
REQ-019 Reset mid-job: job aborted, no resp_valid issued; the first job after reset SHALL take the LOAD path.

Verification
REQ-020 Single job: req_valid=2'b01, B0=identity, A0=counting 1..16 -> LOAD one pulse, START one pulse, resp_valid=2'b01 at accept+19, resp_data = A*I.
REQ-021 Contention: both valid from reset -> requester 0 served first, requester 1 accepted in IDLE after DONE; then both valid again -> requester 0 served (prio alternates).
REQ-022 Parameter reuse: two jobs from requester 0, same B -> second job has no f_load_params pulse, resp_valid at accept+18.
REQ-023 Parameter change: requester 1 with B differing from B_cache -> f_load_params pulses, B_cache updated.
REQ-024 Reset in WAIT at counter=5 -> no resp_valid, busy=0 next cycle; next job pulses f_load_params.
REQ-025 Protocol checks throughout: req_ready zero outside IDLE, resp_valid onehot0 and one cycle wide, f_data_a/f_data_b stable LOAD..DONE.
